req_level_initiator: RTL and testbench
======================================

REQ_LEVEL_INITIATOR -- requirements
Module: req_level_initiator

Interface
REQ-001: Parameter DATA_W, default 32, payload width.
REQ-002: Parameter FIFO_DEPTH, default 4, command buffer depth (power of 2, >=2).
REQ-003: Parameter TIMEOUT_CYC, default 255, max wait cycles per handshake phase; 0 disables timeout.
REQ-004: clk  input  1  single clock; all logic on rising edge.
REQ-005: rst  input  1  asynchronous, active-high reset.
REQ-006: cmd_valid  input  1  upstream command present (pulse or held).
REQ-007: cmd_ready  output  1  command buffer can accept.
REQ-008: cmd_data  input  DATA_W  command payload.
REQ-009: req  output  1  level request to the responder (4-phase).
REQ-010: req_data  output  DATA_W  payload, stable while a handshake is in progress.
REQ-011: ack  input  1  responder acknowledge level.
REQ-012: busy  output  1  handshake in progress or buffer non-empty.
REQ-013: done_pulse  output  1  one-cycle pulse on successful handshake completion.
REQ-014: timeout_err  output  1  one-cycle pulse on phase timeout.
REQ-015: fifo_level  output  $clog2(FIFO_DEPTH)+1  buffered command count.

Function
REQ-016: Push when cmd_valid && cmd_ready; cmd_ready = !full; no push while full, even with a simultaneous pop.
REQ-017: ack registered once (ack_q) before use; all ack decisions use ack_q.
REQ-018: FSM states IDLE, REQ_HI, REQ_LO.
REQ-019: IDLE, FIFO non-empty and ack_q==0 -> pop head into req_data register, REQ_HI; req=1 from next cycle.
REQ-020: IDLE with ack_q==1 (stale ack) waits in IDLE; no pop.
REQ-021: REQ_HI, req=1, ack_q==1 -> REQ_LO; req=0 from next cycle.
REQ-022: REQ_LO, req=0, ack_q==0 -> IDLE, done_pulse=1 for that cycle.
REQ-023: Latency: push into empty FIFO in cycle N, IDLE -> req high at N+1.
REQ-024: req low minimum 2 cycles between back-to-back commands (REQ_LO exit, IDLE pop).
REQ-025: req_data changes only at pop; held through REQ_HI and REQ_LO.
REQ-026: Phase counter cleared on every state entry, increments each cycle in REQ_HI/REQ_LO, saturates.
REQ-027: REQ_HI counter == TIMEOUT_CYC (nonzero) -> REQ_LO, timeout_err pulse; command dropped, no done_pulse.
REQ-028: REQ_LO counter == TIMEOUT_CYC (nonzero) -> IDLE, timeout_err pulse, no done_pulse.
REQ-029: Exactly one of done_pulse/timeout_err per popped command, except REQ_HI timeout followed by REQ_LO completion yields timeout_err only.
REQ-030: Push and pop in the same cycle (not full) leaves fifo_level unchanged.
REQ-031: busy = (state != IDLE) || fifo_level != 0.

Reset
REQ-032: rst asserted: req=0, req_data=0, cmd_ready=0, done_pulse=0, timeout_err=0, fifo_level=0, busy=0, ack_q=0, state IDLE, FIFO flushed, counter 0.
REQ-033: cmd_ready=1 from first cycle after rst deasserts.
REQ-034: rst mid-handshake drops req immediately (async); buffered commands discarded.

Structure
REQ-035: Package req_init_pkg holds state enum and default parameter constants.
REQ-036: Sub-module req_cmd_fifo (synchronous FIFO, DATA_W x FIFO_DEPTH, full/empty/level).

Verification
REQ-037: Single cmd 0xA5A5_0001, responder acks 3 cycles after req rise, drops 2 cycles after req fall -> one req pulse, req_data stable, one done_pulse, fifo_level returns 0.
REQ-038: 5 cmds pushed back-to-back with FIFO_DEPTH=4, ack never rises -> cmd_ready low after 4th push (5th held), 4 completions in order 1..4, then 5th accepted and completed.
REQ-039: TIMEOUT_CYC=8, ack never rises -> req high 8 cycles, timeout_err one pulse, req low, no done_pulse, next command issued.
REQ-040: ack stuck high at idle with 1 cmd buffered -> no req rise until ack low, then normal handshake.
REQ-041: rst pulsed while req=1 with 2 cmds buffered -> req=0 same cycle, fifo_level=0, no done_pulse.
REQ-042: Simultaneous push and pop at fifo_level=2 -> fifo_level stays 2, order preserved.

Source files
------------

// File: rtl/req_init_pkg.sv
// Shared types and default constants for the level-request initiator.
//   req_state_e : handshake FSM states (idle, request high, request low)
//   Default*    : default parameter values used by the initiator and its FIFO
//   cnt_width   : width needed for a counter that must reach a given value
package req_init_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReqHi = 2'd1,
    StReqLo = 2'd2
  } req_state_e;

  localparam int unsigned DefaultDataW      = 32;
  localparam int unsigned DefaultFifoDepth  = 4;
  localparam int unsigned DefaultTimeoutCyc = 255;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/req_cmd_fifo.sv
// Synchronous command FIFO, DATA_W x FIFO_DEPTH (FIFO_DEPTH a power of two, >= 2).
//   clk, rst : rising-edge clock, asynchronous active-high reset (flushes the FIFO)
//   push     : write wdata when not full (ignored while full, even with a pop)
//   wdata    : write payload
//   pop      : retire the head entry when not empty
//   rdata    : head entry (first-word fall-through)
//   full     : FIFO_DEPTH entries held
//   empty    : no entries held
//   level    : number of entries held
module req_cmd_fifo
  import req_init_pkg::*;
#(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DATA_W-1:0]           wdata,
  input  logic                        pop,
  output logic [DATA_W-1:0]           rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              push_en, pop_en;

  assign full    = (level_q == LvlFull);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + AddrW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
    end
    if (push_en && !pop_en) begin
      level_d = level_q + LvlW'(1);
    end else if (!push_en && pop_en) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/req_level_initiator.sv
// Buffers upstream commands and issues each one to a responder over a 4-phase
// level req/ack handshake, with an optional per-phase timeout.
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   cmd_valid   : upstream command present
//   cmd_ready   : command buffer can accept (low while full or in reset)
//   cmd_data    : command payload
//   req         : level request to the responder
//   req_data    : payload of the handshake in progress, changes only at pop
//   ack         : responder acknowledge level (synchronised once before use)
//   busy        : handshake in progress or commands buffered
//   done_pulse  : one cycle, handshake completed normally
//   timeout_err : one cycle, a handshake phase exceeded TIMEOUT_CYC cycles
//   fifo_level  : number of buffered commands
module req_level_initiator
  import req_init_pkg::*;
#(
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned FIFO_DEPTH  = DefaultFifoDepth,
  parameter int unsigned TIMEOUT_CYC = DefaultTimeoutCyc
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [DATA_W-1:0]           cmd_data,
  output logic                        req,
  output logic [DATA_W-1:0]           req_data,
  input  logic                        ack,
  output logic                        busy,
  output logic                        done_pulse,
  output logic                        timeout_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned CntW      = cnt_width(TIMEOUT_CYC);
  localparam bit          TimeoutEn = (TIMEOUT_CYC != 0);
  // The counter holds cycles already spent in the phase, so the phase expires
  // during the cycle it reads TIMEOUT_CYC-1: exactly TIMEOUT_CYC cycles per phase.
  localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TIMEOUT_CYC - 1) : '0;

  req_state_e        state_q, state_d;
  logic              ack_q;
  logic [DATA_W-1:0] req_data_q;
  logic              timed_out_q, timed_out_d;
  logic [CntW-1:0]   phase_cnt_q, phase_cnt_d;
  logic              phase_expired;

  logic              fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  // Gate with rst so no command is offered or accepted while in reset.
  assign cmd_ready = !rst && !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;

  req_cmd_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (cmd_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign phase_expired = TimeoutEn && (phase_cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    timed_out_d = timed_out_q;
    fifo_pop    = 1'b0;
    done_pulse  = 1'b0;
    timeout_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A stale ack from the previous handshake blocks the next request.
        if (!fifo_empty && !ack_q) begin
          fifo_pop    = 1'b1;
          timed_out_d = 1'b0;
          state_d     = StReqHi;
        end
      end
      StReqHi: begin
        if (ack_q) begin
          state_d = StReqLo;
        end else if (phase_expired) begin
          // Command is dropped; the return-to-zero phase still runs so the
          // responder sees a clean 4-phase sequence.
          state_d     = StReqLo;
          timeout_err = 1'b1;
          timed_out_d = 1'b1;
        end
      end
      StReqLo: begin
        if (!ack_q) begin
          state_d    = StIdle;
          done_pulse = !timed_out_q;
        end else if (phase_expired) begin
          state_d     = StIdle;
          // At most one error report per command.
          timeout_err = !timed_out_q;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Cleared on every state entry, counts while a handshake phase is active.
  always_comb begin
    phase_cnt_d = phase_cnt_q;
    if (state_d != state_q) begin
      phase_cnt_d = '0;
    end else if ((state_q != StIdle) && (phase_cnt_q != '1)) begin
      phase_cnt_d = phase_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ack_q       <= 1'b0;
      req_data_q  <= '0;
      timed_out_q <= 1'b0;
      phase_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack;
      timed_out_q <= timed_out_d;
      phase_cnt_q <= phase_cnt_d;
      if (fifo_pop) begin
        req_data_q <= fifo_head;
      end
    end
  end

  assign req      = (state_q == StReqHi);
  assign req_data = req_data_q;
  assign busy     = (state_q != StIdle) || (fifo_level != '0);

endmodule

// File: tb/tb_req_level_initiator.sv
// Directed bench for req_level_initiator with a transaction-level model of the
// 4-phase protocol checked against every output on every falling clock edge.
module tb_req_level_initiator;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_data;
  logic          req;
  logic [DW-1:0] req_data;
  logic          ack;
  logic          busy;
  logic          done_pulse;
  logic          timeout_err;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  req_level_initiator #(
    .DATA_W      (DW),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .busy        (busy),
    .done_pulse  (done_pulse),
    .timeout_err (timeout_err),
    .fifo_level  (fifo_level)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Protocol model: a queue of buffered commands plus the outstanding handshake
  // described as request level, cycles held in the current level, and whether
  // the command was already dropped by a timeout.
  logic [DW-1:0] mq[$];
  bit            m_in_hs, m_req, m_drop, m_ackd;
  int            m_hold;
  logic [DW-1:0] m_data;

  function automatic void model_reset();
    mq.delete();
    m_in_hs = 0; m_req = 0; m_drop = 0; m_ackd = 0; m_hold = 0; m_data = '0;
  endfunction

  function automatic bit exp_done();
    return m_in_hs && !m_req && !m_ackd && !m_drop;
  endfunction

  function automatic bit exp_tmo();
    return m_in_hs && (TMO != 0) && (m_hold + 1 == TMO) &&
           ((m_req && !m_ackd) || (!m_req && m_ackd && !m_drop));
  endfunction

  function automatic void model_step();
    bit pop, push, tmo;
    pop  = !m_in_hs && (mq.size() != 0) && !m_ackd;
    push = cmd_valid && (mq.size() < DEPTH);
    tmo  = exp_tmo();
    if (m_in_hs) begin
      if (m_req) begin
        if (m_ackd) begin
          m_req = 0; m_hold = 0;
        end else if (tmo) begin
          m_req = 0; m_drop = 1; m_hold = 0;
        end else begin
          m_hold++;
        end
      end else begin
        if (!m_ackd || tmo) begin
          m_in_hs = 0; m_hold = 0;
        end else begin
          m_hold++;
        end
      end
    end
    if (pop) begin
      m_data = mq.pop_front();
      m_in_hs = 1; m_req = 1; m_hold = 0; m_drop = 0;
    end
    if (push) mq.push_back(cmd_data);
    m_ackd = ack;
  endfunction

  // Event log taken from the DUT for the hand-computed scenario checks.
  logic [DW-1:0] rise_log[$];
  int            run_log[$];
  int            run, n_done, n_tmo;
  bit            prev_req;
  // Responder behaviour: 0 never acks, 1 acks 3 cycles after req rise and
  // releases 2 cycles after req fall, 2 holds ack high.
  int            mode, hi_seen, lo_seen;

  function automatic void clear_log();
    rise_log.delete(); run_log.delete(); n_done = 0; n_tmo = 0;
  endfunction

  function automatic logic [DW-1:0] rise_at(input int i);
    if (i < rise_log.size()) return rise_log[i];
    return 'x;
  endfunction

  function automatic int run_at(input int i);
    if (i < run_log.size()) return run_log[i];
    return -1;
  endfunction

  task automatic compare_all();
    chk("req", req, m_req);
    chk("req_data", req_data, m_data);
    chk("cmd_ready", cmd_ready, !rst && (mq.size() < DEPTH));
    chk("fifo_level", fifo_level, mq.size());
    chk("busy", busy, m_in_hs || (mq.size() != 0));
    chk("done_pulse", done_pulse, exp_done());
    chk("timeout_err", timeout_err, exp_tmo());
  endtask

  task automatic observe();
    if (req && !prev_req) begin
      rise_log.push_back(req_data);
      run = 0;
    end
    if (req) run++;
    if (!req && prev_req) run_log.push_back(run);
    if (done_pulse) n_done++;
    if (timeout_err) n_tmo++;
    prev_req = req;
  endtask

  task automatic respond();
    case (mode)
      1: begin
        if (req) begin
          hi_seen++; lo_seen = 0;
          if (hi_seen >= 3) ack = 1'b1;
        end else begin
          lo_seen++; hi_seen = 0;
          if (lo_seen >= 2) ack = 1'b0;
        end
      end
      2: ack = 1'b1;
      default: ack = 1'b0;
    endcase
  endtask

  // One clock: model advances on the rising edge, DUT checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    compare_all();
    observe();
    respond();
  endtask

  task automatic push(input logic [DW-1:0] d);
    bit rdy;
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    do begin
      rdy = cmd_ready;
      tick();
      n++;
    end while (!rdy && n < 200);
    cmd_valid = 1'b0;
    chk("push_accepted", rdy, 1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; ack = 1'b0;
    mode = 0; hi_seen = 0; lo_seen = 0; prev_req = 0; run = 0;
    model_reset();
    clear_log();
    tick();
    tick();
    chk("reset_req", req, 0);
    chk("reset_req_data", req_data, 0);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_fifo_level", fifo_level, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", cmd_ready, 1);

    // Single command, responder acks 3 cycles after rise, releases 2 after fall.
    mode = 1;
    clear_log();
    push(32'hA5A5_0001);
    wait_idle(100);
    chk("s1_rises", rise_log.size(), 1);
    chk("s1_data", rise_at(0), 32'hA5A5_0001);
    chk("s1_high_cycles", run_at(0), 4);
    chk("s1_done", n_done, 1);
    chk("s1_timeouts", n_tmo, 0);
    chk("s1_level", fifo_level, 0);

    // Timeout: no ack, req held exactly TMO cycles, next command still issued.
    mode = 0;
    clear_log();
    push(32'h0000_0039);
    push(32'h0000_003A);
    wait_idle(100);
    chk("s2_high_cycles", run_at(0), 8);
    chk("s2_timeouts", n_tmo, 2);
    chk("s2_done", n_done, 0);
    chk("s2_rises", rise_log.size(), 2);
    chk("s2_second_data", rise_at(1), 32'h0000_003A);

    // Fill: a dummy command occupies the handshake while 4 more fill the FIFO.
    clear_log();
    push(32'h0000_00D0);
    for (int i = 1; i <= 4; i++) push(DW'(i));
    chk("s3_full_ready", cmd_ready, 0);
    chk("s3_full_level", fifo_level, 4);
    push(32'd5);
    wait_idle(300);
    chk("s3_rises", rise_log.size(), 6);
    for (int i = 1; i <= 5; i++) chk("s3_order", rise_at(i), DW'(i));
    chk("s3_timeouts", n_tmo, 6);

    // Stale ack held at idle blocks the request until it is released.
    mode = 2;
    ack = 1'b1;
    tick();
    tick();
    clear_log();
    push(32'h0000_0040);
    repeat (5) tick();
    chk("s4_no_req", req, 0);
    chk("s4_held", fifo_level, 1);
    mode = 1;
    wait_idle(100);
    chk("s4_rises", rise_log.size(), 1);
    chk("s4_done", n_done, 1);

    // Push and pop in the same cycle at level 2.
    mode = 2;
    ack = 1'b1;
    tick();
    tick();
    clear_log();
    push(32'h0000_0421);
    push(32'h0000_0422);
    chk("s5_level_before", fifo_level, 2);
    mode = 0;
    ack = 1'b0;
    tick();
    cmd_valid = 1'b1;
    cmd_data  = 32'h0000_0423;
    chk("s5_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("s5_level_kept", fifo_level, 2);
    chk("s5_req", req, 1);
    mode = 1;
    wait_idle(200);
    chk("s5_first", rise_at(0), 32'h0000_0421);
    chk("s5_second", rise_at(1), 32'h0000_0422);
    chk("s5_third", rise_at(2), 32'h0000_0423);
    chk("s5_done", n_done, 3);

    // Reset mid-handshake with two commands buffered.
    mode = 0;
    push(32'h0000_0411);
    push(32'h0000_0412);
    push(32'h0000_0413);
    chk("s6_req_before", req, 1);
    chk("s6_level_before", fifo_level, 2);
    clear_log();
    #2 rst = 1'b1;
    #1;
    chk("s6_req_drop", req, 0);
    chk("s6_level_flush", fifo_level, 0);
    chk("s6_busy", busy, 0);
    chk("s6_ready_in_reset", cmd_ready, 0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    chk("s6_ready_after", cmd_ready, 1);
    chk("s6_no_done", n_done, 0);
    mode = 1;
    push(32'h0000_005A);
    wait_idle(100);
    chk("s6_post_done", n_done, 1);
    chk("s6_post_data", rise_at(0), 32'h0000_005A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
